// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the FM spy-buffer initialization sequencer.
package fm_sb_pkg;

   localparam int sb_mapped_n       = 8;
   localparam int FM_SB_INIT_SETTLE = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SCAN,
      ST_WRITE,
      ST_FINISH
   } fm_sb_init_state_t;

endpackage

// File: rtl/fm_sb_init_seq.sv
// Spy-buffer initialization sequencer: freezes unmasked buffers, zero-fills each one
// through the shared write port, then releases freeze and flags completion.
module fm_sb_init_seq
   import fm_sb_pkg::*;
#(
   parameter int SB_N   = sb_mapped_n,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int SETTLE = FM_SB_INIT_SETTLE,
   localparam int SEL_W = (SB_N > 1) ? $clog2(SB_N) : 1
) (
   input  logic              axi_clk,
   input  logic              axi_reset,
   input  logic              init_req,
   input  logic              abort_req,
   input  logic [SB_N-1:0]   sb_mask,
   input  logic [SB_N-1:0]   freeze_in,
   output logic [SB_N-1:0]   freeze_out,
   output logic [SEL_W-1:0]  mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SB_N - 1);

   fm_sb_init_state_t state, state_nxt;
   logic              req_d;
   logic [CNT_W-1:0]  settle_cnt, cnt_nxt;
   logic [SEL_W-1:0]  sel_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              done_nxt, aborted_nxt;
   logic              start, frz_hold, sel_last, addr_last;

   assign start     = init_req & ~req_d;
   assign sel_last  = (mem_sel == SEL_LAST);
   assign addr_last = &mem_addr;

   // Write handshake: a write transfers in any cycle with mem_we & mem_ready; while
   // mem_ready is low mem_we stays high and mem_sel/mem_addr/mem_wdata hold steady.
   assign busy       = (state != ST_IDLE);
   assign frz_hold   = (state != ST_IDLE);
   assign mem_we     = (state == ST_WRITE);
   assign mem_wdata  = '0;
   assign freeze_out = freeze_in | ({SB_N{frz_hold}} & ~sb_mask);

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         state      <= ST_IDLE;
         req_d      <= 1'b0;
         settle_cnt <= '0;
         mem_sel    <= '0;
         mem_addr   <= '0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_nxt;
         req_d      <= init_req;
         settle_cnt <= cnt_nxt;
         mem_sel    <= sel_nxt;
         mem_addr   <= addr_nxt;
         done       <= done_nxt;
         aborted    <= aborted_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = settle_cnt;
      sel_nxt     = mem_sel;
      addr_nxt    = mem_addr;
      done_nxt    = done;
      aborted_nxt = aborted;
      case (state)
         ST_IDLE: begin
            if (start) begin
               done_nxt    = 1'b0;
               aborted_nxt = 1'b0;
               sel_nxt     = '0;
               addr_nxt    = '0;
               cnt_nxt     = '0;
               state_nxt   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort_req) begin
               aborted_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else if (settle_cnt == CNT_LAST) begin
               state_nxt = ST_SCAN;
            end else begin
               cnt_nxt = settle_cnt + 1'b1;
            end
         end
         ST_SCAN: begin
            // The mask is sampled here only, so mid-run mask edits apply at the next scan.
            if (abort_req) begin
               aborted_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else if (!sb_mask[mem_sel]) begin
               addr_nxt  = '0;
               state_nxt = ST_WRITE;
            end else if (sel_last) begin
               state_nxt = ST_FINISH;
            end else begin
               sel_nxt = mem_sel + 1'b1;
            end
         end
         ST_WRITE: begin
            if (abort_req) begin
               aborted_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else if (mem_ready) begin
               if (!addr_last) begin
                  addr_nxt = mem_addr + 1'b1;
               end else if (sel_last) begin
                  state_nxt = ST_FINISH;
               end else begin
                  sel_nxt   = mem_sel + 1'b1;
                  state_nxt = ST_SCAN;
               end
            end
         end
         ST_FINISH: begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fm_sb_init_seq.sv
// Bench for fm_sb_init_seq: table of full runs checked against a write-order scoreboard,
// plus hand-written abort and asynchronous-reset sequences.
module tb_fm_sb_init_seq;

   localparam int SB_N   = 4;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;
   localparam int SETTLE = 2;
   localparam int SEL_W  = 2;
   localparam int W      = 8 + SEL_W + ADDR_W;

   logic              axi_clk;
   logic              axi_reset;
   logic              init_req;
   logic              abort_req;
   logic [SB_N-1:0]   sb_mask;
   logic [SB_N-1:0]   freeze_in;
   logic [SB_N-1:0]   freeze_out;
   logic [SEL_W-1:0]  mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_ready;
   logic              busy;
   logic              done;
   logic              aborted;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   fm_sb_init_seq #(
      .SB_N(SB_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE)
   ) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset), .init_req(init_req), .abort_req(abort_req),
      .sb_mask(sb_mask), .freeze_in(freeze_in), .freeze_out(freeze_out), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
      .busy(busy), .done(done), .aborted(aborted)
   );

   // clock / reset
   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: expected write order and cycle of each write with mem_ready held high.
   task automatic build_expect(input logic [3:0] mask, output int last_busy);
      int t;
      logic [7:0] tc;
      logic [SEL_W-1:0] s;
      logic [ADDR_W-1:0] a;
      exp_q.delete();
      t = SETTLE;
      for (int b = 0; b < SB_N; b++) begin
         t++;
         if (!mask[b]) begin
            for (int ad = 0; ad < (1 << ADDR_W); ad++) begin
               t++;
               tc = t[7:0];
               s  = b[SEL_W-1:0];
               a  = ad[ADDR_W-1:0];
               exp_q.push_back({tc, s, a});
            end
         end
      end
      last_busy = t + 1;
   endtask

   task automatic run_vec(input logic [3:0] mask, input bit stall, input bit glitch,
                          input int exp_accepts);
      int cyc, first_busy, last_busy, exp_last, accepts;
      bit prev_stall;
      logic [ADDR_W-1:0] prev_addr;
      logic [SEL_W-1:0] prev_sel;
      logic [W-1:0] e, g;
      build_expect(mask, exp_last);
      init_req  = 1'b0;
      sb_mask   = mask;
      mem_ready = 1'b1;
      repeat (2) @(posedge axi_clk);
      #1 init_req = 1'b1;
      cyc = 0; first_busy = -1; last_busy = -1; accepts = 0; prev_stall = 0;
      prev_addr = '0; prev_sel = '0;
      forever begin
         @(negedge axi_clk);
         if (busy) begin
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
            chk("freeze_busy", {28'd0, freeze_out}, {28'd0, freeze_in | ~mask});
         end
         if (stall && prev_stall) begin
            chk("stall_we_held", {31'd0, mem_we}, 32'd1);
            chk("stall_addr_held", {29'd0, mem_addr}, {29'd0, prev_addr});
            chk("stall_sel_held", {30'd0, mem_sel}, {30'd0, prev_sel});
         end
         if (mem_we && mem_ready) begin
            accepts++;
            g = {cyc[7:0], mem_sel, mem_addr};
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {19'd0, g}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (stall) chk("write_order", {19'd0, 8'd0, g[SEL_W+ADDR_W-1:0]},
                              {19'd0, 8'd0, e[SEL_W+ADDR_W-1:0]});
               else       chk("write_cycle_order", {19'd0, g}, {19'd0, e});
               chk("wdata_zero", mem_wdata, 32'd0);
            end
         end
         prev_stall = mem_we && !mem_ready;
         prev_addr  = mem_addr;
         prev_sel   = mem_sel;
         if (!busy && cyc > 0) break;
         if (cyc > 1000) begin
            chk("run_timeout", 32'd1, 32'd0);
            break;
         end
         @(posedge axi_clk);
         #1;
         freeze_in = 4'($urandom_range(0, 15));
         if (stall) mem_ready = ~mem_ready;
         if (glitch && cyc == 10) init_req = 1'b0;
         if (glitch && cyc == 12) init_req = 1'b1;
         cyc++;
      end
      chk("first_busy", first_busy, 32'd1);
      if (!stall) chk("last_busy", last_busy, exp_last);
      chk("accepts", accepts, exp_accepts);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("done_after", {31'd0, done}, 32'd1);
      chk("aborted_after", {31'd0, aborted}, 32'd0);
      chk("freeze_idle", {28'd0, freeze_out}, {28'd0, freeze_in});
      // init_req is still high: the sequencer must not start a second run
      repeat (3) @(negedge axi_clk);
      chk("no_rerun", {31'd0, busy}, 32'd0);
      init_req = 1'b0;
   endtask

   typedef struct {
      logic [3:0] mask;
      bit         stall;
      bit         glitch;
      int         exp_accepts;
   } vec_t;

   vec_t vecs[6];
   int   cyc;

   initial begin
      vecs[0] = '{mask: 4'b0010, stall: 1'b0, glitch: 1'b0, exp_accepts: 24};
      vecs[1] = '{mask: 4'b1111, stall: 1'b0, glitch: 1'b0, exp_accepts: 0};
      vecs[2] = '{mask: 4'b0010, stall: 1'b1, glitch: 1'b0, exp_accepts: 24};
      vecs[3] = '{mask: 4'b0000, stall: 1'b0, glitch: 1'b1, exp_accepts: 32};
      vecs[4] = '{mask: 4'b0000, stall: 1'b1, glitch: 1'b0, exp_accepts: 32};
      vecs[5] = '{mask: 4'b0101, stall: 1'b0, glitch: 1'b0, exp_accepts: 16};

      axi_reset = 1'b1; init_req = 1'b0; abort_req = 1'b0; sb_mask = '0;
      freeze_in = 4'b0101; mem_ready = 1'b1;
      repeat (3) @(posedge axi_clk);
      @(negedge axi_clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_sel", {30'd0, mem_sel}, 32'd0);
      chk("rst_addr", {29'd0, mem_addr}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_aborted", {31'd0, aborted}, 32'd0);
      chk("rst_freeze", {28'd0, freeze_out}, 32'h5);
      @(posedge axi_clk);
      #1 axi_reset = 1'b0;

      for (int i = 0; i < 6; i++)
         run_vec(vecs[i].mask, vecs[i].stall, vecs[i].glitch, vecs[i].exp_accepts);

      // abort during the sel2 write of address 5
      sb_mask = 4'b0010; mem_ready = 1'b1;
      @(posedge axi_clk);
      #1 init_req = 1'b1;
      cyc = 0;
      while (!(mem_we && mem_sel == 2'd2 && mem_addr == 3'd5) && cyc < 200) begin
         @(negedge axi_clk);
         cyc++;
      end
      chk("abort_reach_point", {31'd0, cyc < 200}, 32'd1);
      abort_req = 1'b1;
      @(posedge axi_clk);
      #1 abort_req = 1'b0;
      @(negedge axi_clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_flag", {31'd0, aborted}, 32'd1);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_we", {31'd0, mem_we}, 32'd0);
      chk("abort_freeze", {28'd0, freeze_out}, {28'd0, freeze_in});
      run_vec(4'b0010, 1'b0, 1'b0, 24);

      // asynchronous reset mid-write
      sb_mask = 4'b0000; mem_ready = 1'b1;
      @(posedge axi_clk);
      #1 init_req = 1'b1;
      repeat (8) @(posedge axi_clk);
      #3 axi_reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_we", {31'd0, mem_we}, 32'd0);
      chk("arst_sel", {30'd0, mem_sel}, 32'd0);
      chk("arst_addr", {29'd0, mem_addr}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_freeze", {28'd0, freeze_out}, {28'd0, freeze_in});
      init_req = 1'b0;
      @(posedge axi_clk);
      #2 axi_reset = 1'b0;
      run_vec(4'b0000, 1'b0, 1'b0, 32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fm_sb_init_seq.md
# fm_sb_init_seq

Spy-buffer memory initialization sequencer for the FM block. On a software request it freezes every unmasked spy buffer, walks a single shared write port across the buffers one at a time, and writes zero to every address of each buffer. It then releases freeze and reports completion. It sits between the FM control registers (`SPY_CTRL.INITIALIZE_SPY_MEMORY`, the per-buffer masks) and the spy-buffer memory write mux. Its freeze contribution is ORed with the global freeze path.

## Interface
Parameters:
- `SB_N`, default `sb_mapped_n`: number of spy buffers.
- `ADDR_W`, default 10: spy memory address width; depth is 2^`ADDR_W`.
- `DATA_W`, default 32: spy memory data width.
- `SETTLE`, default 4: cycles freeze is held before the first write; minimum 1.

Ports:
- `axi_clk` in 1: single clock.
- `axi_reset` in 1: reset, asynchronous, active-high.
- `init_req` in 1: level from `INITIALIZE_SPY_MEMORY`; a rising edge starts a run.
- `abort_req` in 1: level; while high in any busy state, the run is aborted.
- `sb_mask` in `SB_N`: bit i = 1 means buffer i is skipped and never frozen by this block.
- `freeze_in` in `SB_N`: per-buffer freeze from the global freeze/playback controller.
- `freeze_out` out `SB_N`: `freeze_in | ({SB_N{frz_hold}} & ~sb_mask)`.
- `mem_sel` out `$clog2(SB_N)`: buffer index addressed by the shared write port.
- `mem_addr` out `ADDR_W`: write address.
- `mem_wdata` out `DATA_W`: constant 0.
- `mem_we` out 1: write valid.
- `mem_ready` in 1: write accepted in a cycle where `mem_we & mem_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: sticky; set on successful completion.
- `aborted` out 1: sticky; set on abort.

## Operation
- States: IDLE, SETTLE, SCAN, WRITE, FINISH.
- Edge detect: `init_req` is registered to `req_d`. `start = init_req & ~req_d`, evaluated only in IDLE. Edges seen while busy are ignored.
- IDLE, on `start`:
  - clear `done`, `aborted`, `mem_sel`, `mem_addr`, and the settle counter;
  - go to SETTLE.
- SETTLE: `frz_hold` = 1. Count `SETTLE` cycles, then go to SCAN.
- SCAN: one cycle per buffer examined.
  - If `sb_mask[mem_sel]` = 0, go to WRITE with `mem_addr` = 0.
  - Else, if `mem_sel` = `SB_N`-1, go to FINISH.
  - Else increment `mem_sel` and stay in SCAN.
- WRITE: `mem_we` = 1.
  - On accept with `mem_addr` < max, increment `mem_addr`.
  - On accept with `mem_addr` = 2^`ADDR_W`-1: if `mem_sel` = `SB_N`-1, go to FINISH; else increment `mem_sel` and go to SCAN.
  - `mem_we` stays high with stable `mem_addr` while `mem_ready` = 0 (no drop, no address change).
- FINISH: `frz_hold` = 1. Set `done`, go to IDLE.
- `frz_hold` is high in SETTLE, SCAN, WRITE and FINISH; low in IDLE.
- Abort:
  - Abort is sampled in SETTLE, SCAN and WRITE.
  - In WRITE, a pending un-accepted write is dropped; a write accepted in the same cycle counts.
  - Next state is IDLE. `aborted` is set; `done` stays 0.
- Mask changes mid-run are honoured only at the next SCAN of a buffer. The mask used for `freeze_out` is live.
- All-masked run: SETTLE, then `SB_N` SCAN cycles, then FINISH. No writes; `done` = 1.

## Timing
- Reset values: state IDLE, `req_d` 0, `mem_sel` 0, `mem_addr` 0, `mem_we` 0, `busy` 0, `done` 0, `aborted` 0. `freeze_out` = `freeze_in`.
- `init_req` rises at cycle 0:
  - `busy` and freeze are asserted at cycle 1;
  - first SCAN at cycle `SETTLE`+1;
  - first write at cycle `SETTLE`+2.
- With `mem_ready` = 1: one write per cycle, 2^`ADDR_W` cycles per buffer, plus one SCAN cycle per examined buffer.
- FINISH is 1 cycle. `done` and IDLE are visible the cycle after FINISH; freeze drops that same cycle.
- All state outputs are registered. `freeze_out` is combinational from registered `frz_hold` and the inputs.
- Reset asserted mid-run returns all outputs to reset values immediately (asynchronous). No completion is reported.

## Structure
- Package `fm_sb_pkg`: the state enum `fm_sb_init_state_t`, and the `SETTLE` default constant `FM_SB_INIT_SETTLE`.
- Single flat module; no sub-module is needed. The edge detector is inline.

## Test plan
- `SB_N`=4, `ADDR_W`=3, `SETTLE`=2, mask=4'b0010, `mem_ready`=1, edge at cycle 0 → busy cycles 1–31:
  - writes sel0 at cycles 4–11, sel2 at 14–21, sel3 at 23–30;
  - sel1 is never written or frozen;
  - `done` = 1 and `freeze_out` = `freeze_in` from cycle 32.
- Same setup, `mem_ready` toggling 1/0 → each address is written exactly once, in order. `mem_addr` is stable while stalled; 32 accepts total per full run of 4 buffers.
- mask=4'b1111 → busy cycles 1–7 (2 SETTLE, 4 SCAN, 1 FINISH); no `mem_we`; `done` = 1.
- `abort_req` pulse during a sel2 write at addr 5 → IDLE next cycle, `aborted` = 1, `done` = 0. A subsequent `init_req` edge clears `aborted` and completes normally.
- `init_req` held high, plus extra edges mid-run → exactly one run. A new run requires low-then-high after returning to IDLE.
- `axi_reset` pulsed mid-WRITE (asynchronous, between clock edges) → outputs go to reset values immediately; the next edge starts a fresh run from sel0 addr0.
